// File: rtl/mult_arb_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and watchdog limit.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // A healthy multiplier raises its flag n cycles into RUN; allow a few spare.
  localparam int WD_MARGIN = 4;

  function automatic int wd_limit(input int n);
    return n + WD_MARGIN;
  endfunction

endpackage

// File: rtl/mult_arb_if.sv
// Requester-side bus of the multiplier arbiter.
// MULT_ARB_TIMEOUT_EN adds the err pulse that accompanies done on a watchdog expiry.
interface mult_arb_if #(
  parameter int n    = 231,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*n-1:0] op_a;
  logic [NREQ*n-1:0] op_b;
  logic [n-1:0]      p;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [n-1:0]      result;
  logic              busy;
`ifdef MULT_ARB_TIMEOUT_EN
  logic              err;

  modport master (output req, op_a, op_b, p,
                  input  grant, done, result, busy, err);
  modport slave  (input  req, op_a, op_b, p,
                  output grant, done, result, busy, err);
`else
  modport master (output req, op_a, op_b, p,
                  input  grant, done, result, busy);
  modport slave  (input  req, op_a, op_b, p,
                  output grant, done, result, busy);
`endif
endinterface

// File: rtl/mult_arbiter_rr_picker.sv
// Rotating-priority encoder: search starts one past i_ptr and the first set request wins.
module rr_picker #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_win,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!o_any && i_req[IW'((int'(i_ptr) + k) % NREQ)]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NREQ);
      end
    end
    o_win = o_any ? ({{(NREQ-1){1'b0}}, 1'b1} << o_idx) : '0;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin share of one modular multiplier between NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a RUN watchdog that forces DONE with err=1, result=0.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int n    = 231,
  parameter int NREQ = 4
) (
  input  logic         clk,
  input  logic         reset,
  mult_arb_if.slave    arb,
  output logic         mul_reset,
  output logic [n-1:0] mul_a,
  output logic [n-1:0] mul_b,
  output logic [n-1:0] mul_p,
  input  logic [n-1:0] mul_m,
  input  logic         mul_flag
);

  localparam int IW = $clog2(NREQ);

  state_e          r_state, w_next;
  logic [IW-1:0]   r_rr_ptr, r_win_idx;
  logic [NREQ-1:0] r_grant;
  logic [n-1:0]    r_a, r_b, r_result;

  logic [NREQ-1:0] w_win;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_timeout;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .i_req (arb.req),
    .i_ptr (r_rr_ptr),
    .o_win (w_win),
    .o_idx (w_idx),
    .o_any (w_any)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(wd_limit(n) + 1);

  logic [WDW-1:0] r_wd;
  logic           r_err;

  assign w_timeout = (r_state == RUN) && !mul_flag && (r_wd == WDW'(wd_limit(n)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else if (r_state == LOAD) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else if (r_state == RUN) begin
      r_wd <= r_wd + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign arb.err = (r_state == DONE) && r_err;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (mul_flag || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands are captured only at grant so the bit-serial multiplier sees a stable B.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= IW'(NREQ - 1);
      r_win_idx <= '0;
      r_grant   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_any) begin
          r_a       <= arb.op_a[int'(w_idx)*n +: n];
          r_b       <= arb.op_b[int'(w_idx)*n +: n];
          r_grant   <= w_win;
          r_win_idx <= w_idx;
        end
        RUN: begin
          if (mul_flag)       r_result <= mul_m;
          else if (w_timeout) r_result <= '0;
        end
        DONE: begin
          r_rr_ptr <= r_win_idx;
          r_grant  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign arb.grant  = r_grant;
  assign arb.done   = (r_state == DONE) ? r_grant : '0;
  assign arb.result = r_result;
  assign arb.busy   = (r_state != IDLE);
  assign mul_reset  = reset || (r_state == LOAD);
  assign mul_a      = r_a;
  assign mul_b      = r_b;
  assign mul_p      = arb.p;

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one modular_multiplier instance between NREQ requesters, e.g. point-add, point-double and inversion sequencers of the scalar-multiplication core.
- Arbitrates round-robin and latches the granted operands.
- Starts the multiplier with a one-cycle reset pulse, waits for its done flag, then returns the product to the granted requester with a one-cycle done pulse.

Parameters:
- n, 231, operand/modulus width (must match the multiplier's n).
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held until that requester's done
- op_a  in  NREQ*n  requester i operand A in bits [i*n +: n]
- op_b  in  NREQ*n  requester i operand B, same packing
- p  in  n  field modulus; shared, static during operation; p < 2^(n-1)
- grant  out  NREQ  one-hot; high for the requester being serviced, LOAD through DONE
- done  out  NREQ  one-hot, one-cycle pulse; result valid for that requester
- result  out  n  product of the last completed op; held until the next DONE
- busy  out  1  high in every state except IDLE
- mul_reset  out  1  drives multiplier reset
- mul_a  out  n  multiplier A; registered
- mul_b  out  n  multiplier B; registered
- mul_p  out  n  multiplier p; wired to p
- mul_m  in  n  multiplier result M
- mul_flag  in  1  multiplier finished flag

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=NREQ-1
  - grant=0, done=0, result=0, busy=0
  - mul_a=0, mul_b=0
- mul_reset = reset OR (state==LOAD). Asserting reset mid-operation therefore also clears the multiplier.
- States:
  - IDLE: if any req bit is high, pick the winner and go to LOAD. Latch mul_a, mul_b and grant from the winner's slice. Otherwise stay in IDLE.
  - LOAD: exactly one cycle, mul_reset=1. Clears the multiplier's counter and stale flag. Go to RUN.
  - RUN: hold mul_a and mul_b constant, because the multiplier reads B bit-serially every cycle. When mul_flag=1, register result<=mul_m and go to DONE.
  - DONE: one cycle. done[winner]=1. rr_ptr<=winner. grant cleared on exit. Go to IDLE.
- Round-robin arbitration:
  - Search starts at rr_ptr+1 (mod NREQ) and the first set req bit wins.
  - After reset, req0 has highest priority.
- Latency: if req is sampled in IDLE at cycle t:
  - LOAD at t+1
  - RUN t+2..t+n+2 (mul_flag first high at t+n+2)
  - done at t+n+3
  - Next IDLE at t+n+4.
  - Back-to-back throughput is n+4 cycles per product.
- Requester rules:
  - A requester drops req in the cycle after its done.
  - If req is still high in IDLE, it is a new request. rr_ptr has already moved past it, so it wins only if no other req is set.
- Boundary cases:
  - A req bit that falls while its op is in flight does not abort the op; done still pulses.
  - Operand changes on op_a/op_b after grant are ignored.
  - p changes mid-operation are undefined.

Optional Feature:
- MULT_ARB_TIMEOUT_EN defined:
  - Adds output port err (1 bit, reset 0) and a watchdog counter cleared in LOAD.
  - If RUN lasts more than n+4 cycles without mul_flag, go to DONE with result=0 and err=1, pulsed with done.
  - err=0 on normal completion.
- Not defined: no err port, no counter; RUN waits indefinitely.

Decomposition:
- Package mult_arb_pkg:
  - state enum {IDLE, LOAD, RUN, DONE}
  - localparam for the watchdog limit (n+4)
- Sub-module rr_picker (NREQ):
  - Combinational rotate-priority encoder.
  - Inputs: req, rr_ptr. Outputs: one-hot winner and its index.
- The arbiter FSM, operand latches and result register stay in mult_arbiter.

Test Plan:
All scenarios use n=8, NREQ=4, p=113, with a real modular_multiplier attached.
- Single request: req0 with a=7, b=9 -> grant=0001 from t+1; done=0001 at t+11; result=63; busy low at t+12.
- Second operand pair: req1 with a=100, b=50 -> result=28 (5000 mod 113) with done=0010.
- Simultaneous requests after reset: req0 and req2 high together, each dropped after its own done -> service order 0 then 2, done pulses 12 cycles apart, no gap cycles beyond IDLE.
- Fairness: req0..req3 held continuously (re-requesting) -> grant sequence 0,1,2,3,0; no requester starves.
- Mid-operation reset: reset pulsed in RUN cycle 5 -> next cycle state=IDLE, grant=0, done=0, result=0, mul_reset high during reset; a following req0 with a=7, b=9 completes correctly with result=63.
- With MULT_ARB_TIMEOUT_EN: mul_flag tied to 0 -> done[winner] and err both high at t+15, result=0; without the macro, busy stays high indefinitely.
